// File: rtl/seq_gen_pkg.sv
// ============================================================================
// Module   : seq_gen_pkg
// Purpose  : Shared state encoding and ALU op codes for the recurrence
//            sequence controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEED_ADDR = 3'd1,
        ST_SEED_WAIT = 3'd2,
        ST_SEED_WR   = 3'd3,
        ST_RD        = 3'd4,
        ST_CALC      = 3'd5,
        ST_WR        = 3'd6,
        ST_DONE      = 3'd7
    } seq_state_e;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_XOR = 2;
    localparam int OP_AND = 3;

endpackage

`default_nettype wire

// File: rtl/seq_ovf_detect.sv
// ============================================================================
// Module   : seq_ovf_detect
// Purpose  : Signed two's-complement addition overflow detector for y = a + b.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_ovf_detect #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] y_i,
    output logic          ovf_o
);

    assign ovf_o = (a_i[DW-1] == b_i[DW-1]) && (y_i[DW-1] != a_i[DW-1]);

endmodule

`default_nettype wire

// File: rtl/seq_gen_ctrl.sv
// ============================================================================
// Module   : seq_gen_ctrl
// Purpose  : Seeds regfile[0..1] from RAM, then produces
//            term[i] = term[i-2] OP term[i-1] into regfile and RAM.
//            Optional macro SEQ_OVF_EN enables the sticky ADD-overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_gen_ctrl
    import seq_gen_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int AW    = 6,
    parameter int DEPTH = 32,
    parameter int OPW   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [RW:0]    n_terms,
    input  logic [OPW-1:0] mode,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic [RW-1:0]  r1_addr,
    output logic [RW-1:0]  r2_addr,
    input  logic [DW-1:0]  r1_out,
    input  logic [DW-1:0]  r2_out,
    output logic [RW-1:0]  r3_addr,
    output logic [DW-1:0]  r3_in,
    output logic           r3_we,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_out,
    output logic [AW-1:0]  addrb,
    input  logic [DW-1:0]  doutb,
    output logic [AW-1:0]  addra,
    output logic [DW-1:0]  dina,
    output logic           wea
);

    localparam logic [RW:0] C_N_MIN = (RW+1)'(2);
    localparam logic [RW:0] C_N_MAX = (RW+1)'(DEPTH);

    seq_state_e     state_q, state_d;
    logic [RW-1:0]  idx_q, idx_d, last_q, last_d;
    logic           busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [RW-1:0]  r1a_q, r1a_d, r2a_q, r2a_d, r3a_q, r3a_d;
    logic [DW-1:0]  r3d_q, r3d_d, a_q, a_d, b_q, b_d, dina_q, dina_d;
    logic           r3we_q, r3we_d, wea_q, wea_d;
    logic [OPW-1:0] op_q, op_d;
    logic [AW-1:0]  addrb_q, addrb_d, addra_q, addra_d;
    logic [RW:0]    w_n;

    assign w_n = (n_terms < C_N_MIN) ? C_N_MIN :
                 (n_terms > C_N_MAX) ? C_N_MAX : n_terms;

`ifdef SEQ_OVF_EN
    logic w_ovf_hit;

    seq_ovf_detect #(
        .DW (DW)
    ) u_ovf_detect (
        .a_i   (a_q),
        .b_i   (b_q),
        .y_i   (alu_out),
        .ovf_o (w_ovf_hit)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            r1a_q   <= '0;
            r2a_q   <= '0;
            r3a_q   <= '0;
            r3d_q   <= '0;
            r3we_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            addrb_q <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            wea_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            r1a_q   <= r1a_d;
            r2a_q   <= r2a_d;
            r3a_q   <= r3a_d;
            r3d_q   <= r3d_d;
            r3we_q  <= r3we_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            addrb_q <= addrb_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            wea_q   <= wea_d;
        end
    end

    // Every output is registered, so outputs belonging to a state are
    // computed on the transition into that state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        r1a_d   = r1a_q;
        r2a_d   = r2a_q;
        r3a_d   = r3a_q;
        r3d_d   = r3d_q;
        r3we_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        addrb_d = addrb_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        wea_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEED_ADDR;
                    idx_d   = '0;
                    last_d  = RW'(w_n - (RW+1)'(1));
                    op_d    = mode;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    addrb_d = '0;
                end
            end
            ST_SEED_ADDR: state_d = ST_SEED_WAIT;
            ST_SEED_WAIT: begin
                state_d = ST_SEED_WR;
                r3we_d  = 1'b1;
                r3a_d   = idx_q;
                r3d_d   = doutb;
            end
            ST_SEED_WR: begin
                if (idx_q == '0) begin
                    state_d = ST_SEED_ADDR;
                    idx_d   = RW'(1);
                    addrb_d = AW'(1);
                end else begin
                    idx_d = RW'(2);
                    if (last_q > RW'(1)) begin
                        state_d = ST_RD;
                        r1a_d   = '0;
                        r2a_d   = RW'(1);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CALC;
                a_d     = r1_out;
                b_d     = r2_out;
            end
            ST_CALC: begin
                state_d = ST_WR;
                r3we_d  = 1'b1;
                wea_d   = 1'b1;
                r3a_d   = idx_q;
                addra_d = AW'(idx_q);
                r3d_d   = alu_out;
                dina_d  = alu_out;
`ifdef SEQ_OVF_EN
                if (w_ovf_hit && (op_q == OPW'(OP_ADD))) begin
                    ovf_d = 1'b1;
                end
`endif
            end
            ST_WR: begin
                if (idx_q == last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RD;
                    idx_d   = idx_q + RW'(1);
                    r1a_d   = idx_q - RW'(1);
                    r2a_d   = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign r1_addr = r1a_q;
    assign r2_addr = r2a_q;
    assign r3_addr = r3a_q;
    assign r3_in   = r3d_q;
    assign r3_we   = r3we_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_op  = op_q;
    assign addrb   = addrb_q;
    assign addra   = addra_q;
    assign dina    = dina_q;
    assign wea     = wea_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_ctrl.sv
// ============================================================================
// Module   : tb_seq_gen_ctrl
// Purpose  : Self-checking bench for seq_gen_ctrl with regfile/ALU/RAM models.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_gen_ctrl;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int AW    = 6;
    localparam int DEPTH = 32;
    localparam int OPW   = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [RW:0]    n_terms;
    logic [OPW-1:0] mode;
    logic           busy, done, ovf;
    logic [RW-1:0]  r1_addr, r2_addr, r3_addr;
    logic [DW-1:0]  r1_out, r2_out, r3_in;
    logic           r3_we;
    logic [DW-1:0]  alu_a, alu_b, alu_out;
    logic [OPW-1:0] alu_op;
    logic [AW-1:0]  addrb, addra;
    logic [DW-1:0]  doutb, dina;
    logic           wea;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_gen_ctrl #(
        .DW(DW), .RW(RW), .AW(AW), .DEPTH(DEPTH), .OPW(OPW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms), .mode(mode),
        .busy(busy), .done(done), .ovf(ovf),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_out(r1_out), .r2_out(r2_out),
        .r3_addr(r3_addr), .r3_in(r3_in), .r3_we(r3_we),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .addrb(addrb), .doutb(doutb), .addra(addra), .dina(dina), .wea(wea)
    );

    // ---------------- environment: regfile, ALU, dual-port RAM -------------
    logic [DW-1:0] regf [0:31];
    logic [DW-1:0] ram  [0:63];
    logic          pre_we;
    logic [5:0]    pre_addr;
    logic [DW-1:0] pre_data;

    assign r1_out = regf[r1_addr];
    assign r2_out = regf[r2_addr];

    always_comb begin
        case (alu_op)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
            if (pre_addr < 6'd32) regf[pre_addr[4:0]] <= pre_data;
        end
        if (r3_we) regf[r3_addr] <= r3_in;
        if (wea)   ram[addra]    <= dina;
        doutb <= ram[addrb];
    end

    // ---------------- reference model -------------------------------------
    logic [DW-1:0] exp_t [0:31];
    int            exp_n, exp_dc;
    logic          exp_ovf;

    function automatic void mdl_run(input logic [31:0] s0, input logic [31:0] s1,
                                    input logic [1:0] md, input int n_in);
        logic [31:0] a, b, y;
        exp_n   = (n_in < 2) ? 2 : ((n_in > DEPTH) ? DEPTH : n_in);
        exp_t[0] = s0;
        exp_t[1] = s1;
        exp_ovf = 1'b0;
        for (int i = 2; i < exp_n; i++) begin
            a = exp_t[i-2];
            b = exp_t[i-1];
            case (md)
                2'd0:    y = a + b;
                2'd1:    y = a - b;
                2'd2:    y = a ^ b;
                default: y = a & b;
            endcase
            exp_t[i] = y;
            if (md == 2'd0 && a[31] == b[31] && y[31] != a[31]) exp_ovf = 1'b1;
        end
`ifndef SEQ_OVF_EN
        exp_ovf = 1'b0;
`endif
        exp_dc = 6 + 3 * (exp_n - 2);
    endfunction

    // ---------------- observations of one run ------------------------------
    int         obs_done_cyc, obs_done_cnt, obs_seed_wea, obs_busy_err, obs_last_addra;
    logic       obs_ovf0, obs_ovf_end;
    logic [5:0] wq_a [$];
    logic [31:0] wq_d [$];

    task automatic load_seeds(input logic [31:0] s0, input logic [31:0] s1);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = 6'(i);
            pre_data = (i == 0) ? s0 : ((i == 1) ? s1 : (32'hDEAD_0000 | 32'(i)));
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drives one start and observes cycle k = k-th interval after the
    // start-sampling edge; bounded by the model's done cycle plus slack.
    task automatic do_run(input int n_in, input logic [1:0] md,
                          input int pa, input int pb, input int rst_k);
        int limit;
        limit          = exp_dc + 8;
        obs_done_cyc   = -1;
        obs_done_cnt   = 0;
        obs_seed_wea   = 0;
        obs_busy_err   = 0;
        obs_last_addra = -1;
        wq_a.delete();
        wq_d.delete();
        @(negedge clk);
        n_terms = (RW+1)'(n_in);
        mode    = md;
        start   = 1'b1;
        for (int k = 0; k <= limit; k++) begin
            @(negedge clk);
            if (k == 0) obs_ovf0 = ovf;
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = k;
            end
            if (wea) begin
                wq_a.push_back(addra);
                wq_d.push_back(dina);
                obs_last_addra = int'(addra);
                if (k < 6) obs_seed_wea++;
            end
            if (busy !== (k <= exp_dc)) obs_busy_err++;
            obs_ovf_end = ovf;
            start = (k == pa || k == pb);
            if (k == rst_k) begin
                rst_n = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    function automatic int term_errs();
        int bad = 0;
        for (int i = 0; i < exp_n; i++)
            if (regf[i] !== exp_t[i] || ram[i] !== exp_t[i]) bad++;
        return bad;
    endfunction

    function automatic int wea_errs();
        int bad = 0;
        if (wq_a.size() != exp_n - 2) bad++;
        for (int j = 0; j < wq_a.size(); j++)
            if (int'(wq_a[j]) != j + 2 || wq_d[j] !== exp_t[(j + 2) % 32]) bad++;
        return bad;
    endfunction

    // ---------------- tests -----------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ovf, r3_we, wea} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, ovf, r3_we, wea});
        end
        checks++;
        if ({r1_addr, r2_addr, r3_addr, r3_in, alu_a, alu_b, alu_op, addrb, addra, dina} !== '0) begin
            failures++;
            $display("FAIL reset_buses: got nonzero expected 0 (addrb=%0d addra=%0d r3_in=%h)",
                     addrb, addra, r3_in);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fib();
        load_seeds(32'd1, 32'd1);
        mdl_run(32'd1, 32'd1, 2'd0, 10);
        do_run(10, 2'd0, -1, -1, -1);
        checks++;
        if (obs_done_cyc != 30) begin
            failures++;
            $display("FAIL fib_done_cycle: got %0d expected 30", obs_done_cyc);
        end
        checks++;
        if (term_errs() != 0) begin
            failures++;
            $display("FAIL fib_terms: got %0d bad entries expected 0 (ram[9]=%0d)", term_errs(), ram[9]);
        end
        checks++;
        if (wea_errs() != 0) begin
            failures++;
            $display("FAIL fib_wea: got %0d pulses/errors %0d expected %0d pulses", wq_a.size(), wea_errs(), exp_n - 2);
        end
    endtask

    task automatic test_sub();
        load_seeds(32'd10, 32'd3);
        mdl_run(32'd10, 32'd3, 2'd1, 5);
        do_run(5, 2'd1, -1, -1, -1);
        checks++;
        if (ram[3] !== 32'hFFFF_FFFC || term_errs() != 0) begin
            failures++;
            $display("FAIL sub_terms: got ram[3]=%h expected fffffffc, bad=%0d", ram[3], term_errs());
        end
        checks++;
        if (wq_a.size() != 3 || wea_errs() != 0) begin
            failures++;
            $display("FAIL sub_wea: got %0d pulses expected 3", wq_a.size());
        end
        checks++;
        if (obs_done_cyc != exp_dc || obs_busy_err != 0) begin
            failures++;
            $display("FAIL sub_timing: got done=%0d busy_err=%0d expected done=%0d busy_err=0",
                     obs_done_cyc, obs_busy_err, exp_dc);
        end
    endtask

    task automatic test_clamp();
        load_seeds($urandom, $urandom);
        mdl_run(ram[0], ram[1], 2'd2, 0);
        do_run(0, 2'd2, -1, -1, -1);
        checks++;
        if (obs_done_cyc != 6 || wq_a.size() != 0 || term_errs() != 0) begin
            failures++;
            $display("FAIL clamp_min: got done=%0d wea=%0d expected done=6 wea=0",
                     obs_done_cyc, wq_a.size());
        end
        load_seeds($urandom, $urandom);
        mdl_run(ram[0], ram[1], 2'd0, 40);
        do_run(40, 2'd0, -1, -1, -1);
        checks++;
        if (obs_last_addra != 31 || obs_done_cyc != 96 || wea_errs() != 0) begin
            failures++;
            $display("FAIL clamp_max: got last_addra=%0d done=%0d expected 31 and 96",
                     obs_last_addra, obs_done_cyc);
        end
        checks++;
        if (term_errs() != 0 || obs_seed_wea != 0) begin
            failures++;
            $display("FAIL clamp_max_terms: got bad=%0d seed_wea=%0d expected 0 and 0",
                     term_errs(), obs_seed_wea);
        end
    endtask

    task automatic test_start_ignored();
        load_seeds(32'd2, 32'd5);
        mdl_run(32'd2, 32'd5, 2'd0, 10);
        do_run(10, 2'd0, 5, 12, -1);
        checks++;
        if (obs_done_cnt != 1 || obs_done_cyc != 30 || obs_busy_err != 0) begin
            failures++;
            $display("FAIL start_ignored: got dones=%0d at %0d busy_err=%0d expected 1 at 30 busy_err=0",
                     obs_done_cnt, obs_done_cyc, obs_busy_err);
        end
        checks++;
        if (term_errs() != 0) begin
            failures++;
            $display("FAIL start_ignored_terms: got %0d bad expected 0", term_errs());
        end
    endtask

    task automatic test_reset_mid();
        load_seeds(32'd1, 32'd1);
        mdl_run(32'd1, 32'd1, 2'd0, 10);
        do_run(10, 2'd0, -1, -1, 14);
        @(negedge clk);
        checks++;
        if ({busy, done, r3_we, wea, ovf} !== 5'b0 || {addra, addrb, dina, r3_in} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b addra=%0d expected 0",
                     {busy, done, r3_we, wea, ovf}, addra);
        end
        rst_n = 1'b1;
        load_seeds(32'd4, 32'd7);
        mdl_run(32'd4, 32'd7, 2'd0, 10);
        do_run(10, 2'd0, -1, -1, -1);
        checks++;
        if (obs_done_cyc != 30 || term_errs() != 0 || wea_errs() != 0) begin
            failures++;
            $display("FAIL reset_rerun: got done=%0d bad=%0d expected 30 and 0",
                     obs_done_cyc, term_errs());
        end
    endtask

    task automatic test_back_to_back();
        int first, second, third;
        load_seeds(32'd3, 32'd9);
        mdl_run(32'd3, 32'd9, 2'd3, 4);
        first = -1; second = -1; third = -1;
        @(negedge clk);
        n_terms = 6'd4;
        mode    = 2'd3;
        start   = 1'b1;
        for (int k = 0; k <= 2 * exp_dc + 8; k++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = k;
                else if (second < 0) begin
                    second = k;
                    start  = 1'b0;
                end else third = k;
            end
        end
        start = 1'b0;
        checks++;
        if (first != exp_dc || second != 2 * exp_dc + 2 || third != -1) begin
            failures++;
            $display("FAIL back_to_back: got dones at %0d,%0d,%0d expected %0d,%0d,-1",
                     first, second, third, exp_dc, 2 * exp_dc + 2);
        end
        checks++;
        if (busy !== 1'b0 || term_errs() != 0) begin
            failures++;
            $display("FAIL back_to_back_end: got busy=%b bad=%0d expected 0 and 0", busy, term_errs());
        end
    endtask

    task automatic test_ovf();
        load_seeds(32'h7FFF_FFFF, 32'd1);
        mdl_run(32'h7FFF_FFFF, 32'd1, 2'd0, 4);
        do_run(4, 2'd0, -1, -1, -1);
        checks++;
        if (obs_ovf_end !== exp_ovf || term_errs() != 0) begin
            failures++;
            $display("FAIL ovf_set: got ovf=%b bad=%0d expected ovf=%b", obs_ovf_end, term_errs(), exp_ovf);
        end
        load_seeds(32'd1, 32'd2);
        mdl_run(32'd1, 32'd2, 2'd0, 5);
        do_run(5, 2'd0, -1, -1, -1);
        checks++;
        if (obs_ovf0 !== 1'b0 || obs_ovf_end !== exp_ovf) begin
            failures++;
            $display("FAIL ovf_clear: got ovf0=%b ovf_end=%b expected 0 and %b", obs_ovf0, obs_ovf_end, exp_ovf);
        end
    endtask

    task automatic test_random();
        logic [31:0] s0, s1;
        logic [1:0]  md;
        int          n;
        for (int r = 0; r < 6; r++) begin
            s0 = $urandom;
            s1 = $urandom;
            md = 2'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 40));
            load_seeds(s0, s1);
            mdl_run(s0, s1, md, n);
            do_run(n, md, -1, -1, -1);
            checks++;
            if (obs_done_cyc != exp_dc || obs_done_cnt != 1 || obs_busy_err != 0) begin
                failures++;
                $display("FAIL rand_timing[%0d]: got done=%0d cnt=%0d busy_err=%0d expected done=%0d",
                         r, obs_done_cyc, obs_done_cnt, obs_busy_err, exp_dc);
            end
            checks++;
            if (term_errs() != 0 || wea_errs() != 0 || obs_ovf_end !== exp_ovf) begin
                failures++;
                $display("FAIL rand_data[%0d]: got bad=%0d wea_bad=%0d ovf=%b expected 0,0,%b (n=%0d md=%0d)",
                         r, term_errs(), wea_errs(), obs_ovf_end, exp_ovf, n, md);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        n_terms  = '0;
        mode     = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        test_reset();
        test_fib();
        test_sub();
        test_clamp();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
